// File: rtl/ppi_bus_pkg.sv
// Shared types and constants for the PPI bus-cycle initiator.
package ppi_bus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_STROBE = 3'd2,
        ST_HOLD   = 3'd3,
        ST_RESP   = 3'd4
    } bus_state_e;

    localparam logic [1:0] PPI_PORT_A = 2'd0;
    localparam logic [1:0] PPI_PORT_B = 2'd1;
    localparam logic [1:0] PPI_PORT_C = 2'd2;
    localparam logic [1:0] PPI_CTRL   = 2'd3;

    localparam logic       IDLE_CS_N    = 1'b1;
    localparam logic       IDLE_READ_N  = 1'b1;
    localparam logic       IDLE_WRITE_N = 1'b1;
    localparam logic       IDLE_DATA_OE = 1'b0;
    localparam logic [1:0] IDLE_ADDR    = 2'd0;
    localparam logic [7:0] IDLE_DATA    = 8'h00;
    localparam logic [7:0] ERR_RDATA    = 8'hFF;

    // The control register cannot be read back.
    function automatic logic req_illegal(input logic write, input logic [1:0] addr);
        return (!write) && (addr == PPI_CTRL);
    endfunction

endpackage

// File: rtl/ppi_bus_timer.sv
// Loadable down-counter shared by the SETUP, STROBE and HOLD phases.
module ppi_bus_timer #(
    parameter int unsigned W = 1
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         done_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Reload on phase entry, otherwise count down and saturate at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = (cnt_q == '0);

endmodule

// File: rtl/ppi_bus_master.sv
// Replays queued requests as timed 8255-style read/write cycles on the PPI CPU interface.
module ppi_bus_master
    import ppi_bus_pkg::*;
#(
    parameter int unsigned SETUP_CYCLES  = 1,
    parameter int unsigned STROBE_CYCLES = 2,
    parameter int unsigned HOLD_CYCLES   = 1
) (
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_write,
    input  logic [1:0] req_addr,
    input  logic [7:0] req_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       rsp_err,
    output logic [1:0] A,
    output logic       CS_N,
    output logic       READ_N,
    output logic       WRITE_N,
    output logic [7:0] DATA_OUT,
    output logic       DATA_OE,
    input  logic [7:0] DATA_IN
);

    localparam int unsigned MAX_SS = (SETUP_CYCLES > STROBE_CYCLES) ? SETUP_CYCLES : STROBE_CYCLES;
    localparam int unsigned MAX_CYC = (MAX_SS > HOLD_CYCLES) ? MAX_SS : HOLD_CYCLES;
    localparam int unsigned CW = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    bus_state_e state_q;
    logic       wr_q;
    logic       err_q;
    logic [7:0] rdata_q;
    logic       ready_q;
    logic       rsp_valid_q;
    logic [7:0] rsp_rdata_q;
    logic       rsp_err_q;
    logic [1:0] a_q;
    logic       cs_n_q;
    logic       rd_n_q;
    logic       wr_n_q;
    logic [7:0] dout_q;
    logic       doe_q;

    logic          hs_s;
    logic          illegal_s;
    logic          tmr_load_s;
    logic [CW-1:0] tmr_val_s;
    logic          tmr_done_s;

    assign hs_s      = req_valid & ready_q;
    assign illegal_s = req_illegal(req_write, req_addr);

    // Timer reload value for whichever timed phase is about to be entered.
    always_comb begin
        tmr_load_s = 1'b0;
        tmr_val_s  = '0;
        case (state_q)
            ST_IDLE: begin
                if (hs_s && !illegal_s) begin
                    tmr_load_s = 1'b1;
                    tmr_val_s  = CW'(SETUP_CYCLES - 1);
                end else begin
                    tmr_load_s = 1'b0;
                end
            end
            ST_SETUP: begin
                if (tmr_done_s) begin
                    tmr_load_s = 1'b1;
                    tmr_val_s  = CW'(STROBE_CYCLES - 1);
                end else begin
                    tmr_load_s = 1'b0;
                end
            end
            ST_STROBE: begin
                if (tmr_done_s) begin
                    tmr_load_s = 1'b1;
                    tmr_val_s  = CW'(HOLD_CYCLES - 1);
                end else begin
                    tmr_load_s = 1'b0;
                end
            end
            default: begin
                tmr_load_s = 1'b0;
            end
        endcase
    end

    ppi_bus_timer #(.W(CW)) u_timer (
        .clk_i      (CLK),
        .rst_ni     (RESET_N),
        .load_i     (tmr_load_s),
        .load_val_i (tmr_val_s),
        .done_o     (tmr_done_s)
    );

    // Bus-cycle FSM; every pin and response output is a register.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q     <= ST_IDLE;
            wr_q        <= 1'b0;
            err_q       <= 1'b0;
            rdata_q     <= 8'h00;
            ready_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 8'h00;
            rsp_err_q   <= 1'b0;
            a_q         <= IDLE_ADDR;
            cs_n_q      <= IDLE_CS_N;
            rd_n_q      <= IDLE_READ_N;
            wr_n_q      <= IDLE_WRITE_N;
            dout_q      <= IDLE_DATA;
            doe_q       <= IDLE_DATA_OE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    ready_q <= 1'b1;
                    if (hs_s) begin
                        ready_q <= 1'b0;
                        wr_q    <= req_write;
                        if (illegal_s) begin
                            err_q   <= 1'b1;
                            rdata_q <= ERR_RDATA;
                            state_q <= ST_RESP;
                        end else begin
                            err_q   <= 1'b0;
                            rdata_q <= 8'h00;
                            a_q     <= req_addr;
                            cs_n_q  <= 1'b0;
                            dout_q  <= req_write ? req_wdata : IDLE_DATA;
                            doe_q   <= req_write;
                            state_q <= ST_SETUP;
                        end
                    end
                end
                ST_SETUP: begin
                    if (tmr_done_s) begin
                        rd_n_q  <= wr_q;
                        wr_n_q  <= !wr_q;
                        state_q <= ST_STROBE;
                    end
                end
                ST_STROBE: begin
                    if (tmr_done_s) begin
                        rd_n_q  <= IDLE_READ_N;
                        wr_n_q  <= IDLE_WRITE_N;
                        if (!wr_q) begin
                            rdata_q <= DATA_IN;
                        end
                        state_q <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (tmr_done_s) begin
                        cs_n_q      <= IDLE_CS_N;
                        doe_q       <= IDLE_DATA_OE;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= err_q;
                        rsp_rdata_q <= rdata_q;
                        state_q     <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    // A rejected request arrives here without the pulse raised yet.
                    if (!rsp_valid_q) begin
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= err_q;
                        rsp_rdata_q <= rdata_q;
                    end else begin
                        rsp_valid_q <= 1'b0;
                        rsp_err_q   <= 1'b0;
                        rsp_rdata_q <= 8'h00;
                        ready_q     <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    ready_q     <= 1'b0;
                    rsp_valid_q <= 1'b0;
                    cs_n_q      <= IDLE_CS_N;
                    rd_n_q      <= IDLE_READ_N;
                    wr_n_q      <= IDLE_WRITE_N;
                    doe_q       <= IDLE_DATA_OE;
                end
            endcase
        end
    end

    assign req_ready = ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign A         = a_q;
    assign CS_N      = cs_n_q;
    assign READ_N    = rd_n_q;
    assign WRITE_N   = wr_n_q;
    assign DATA_OUT  = dout_q;
    assign DATA_OE   = doe_q;

endmodule

// File: tb/tb_ppi_bus_master.sv
// Self-checking bench: default-timing and swept-timing instances against a transaction-level model.
module tb_ppi_bus_master;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rv;
    logic       rw;
    logic [1:0] ra;
    logic [7:0] rwd;
    logic [7:0] bus_din;
    logic       sel;

    logic       rvq     [2];
    logic       rdy     [2];
    logic       rsvalid [2];
    logic [7:0] rrd     [2];
    logic       rerr    [2];
    logic [1:0] aa      [2];
    logic       csn     [2];
    logic       rdn     [2];
    logic       wrn     [2];
    logic [7:0] dout    [2];
    logic       doe     [2];
    logic [7:0] din_w   [2];

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    assign rvq[0]   = rv & ~sel;
    assign rvq[1]   = rv & sel;
    // PPI model: drives the read data only while its read strobe is low.
    assign din_w[0] = rdn[0] ? 8'hEE : bus_din;
    assign din_w[1] = rdn[1] ? 8'hEE : bus_din;

    ppi_bus_master dut0 (
        .CLK(clk), .RESET_N(rst_n), .req_valid(rvq[0]), .req_ready(rdy[0]),
        .req_write(rw), .req_addr(ra), .req_wdata(rwd), .rsp_valid(rsvalid[0]),
        .rsp_rdata(rrd[0]), .rsp_err(rerr[0]), .A(aa[0]), .CS_N(csn[0]),
        .READ_N(rdn[0]), .WRITE_N(wrn[0]), .DATA_OUT(dout[0]), .DATA_OE(doe[0]),
        .DATA_IN(din_w[0])
    );

    ppi_bus_master #(.SETUP_CYCLES(3), .STROBE_CYCLES(1), .HOLD_CYCLES(2)) dut1 (
        .CLK(clk), .RESET_N(rst_n), .req_valid(rvq[1]), .req_ready(rdy[1]),
        .req_write(rw), .req_addr(ra), .req_wdata(rwd), .rsp_valid(rsvalid[1]),
        .rsp_rdata(rrd[1]), .rsp_err(rerr[1]), .A(aa[1]), .CS_N(csn[1]),
        .READ_N(rdn[1]), .WRITE_N(wrn[1]), .DATA_OUT(dout[1]), .DATA_OE(doe[1]),
        .DATA_IN(din_w[1])
    );

    task automatic chk(input string tag, input string fld, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s %s: got %0d expected %0d", tag, fld, act, exp);
        end
    endtask

    // Strobe overlap and strobe-without-select are never allowed on either bus.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < 2; i++) begin
                n_chk++;
                if ((!rdn[i] && !wrn[i]) || ((!rdn[i] || !wrn[i]) && csn[i])) begin
                    n_err++;
                    $display("FAIL bus_invariant dut%0d: READ_N=%b WRITE_N=%b CS_N=%b", i, rdn[i], wrn[i], csn[i]);
                end
            end
        end
    end

    // Transaction-level expectation from the cycle budget of each phase.
    function automatic void model(input logic s, input logic w, input logic [1:0] ad, input logic [7:0] din,
                                  output int lat, output int cs, output int sf, output int sc,
                                  output logic [7:0] rd, output logic er);
        int su, st, ho;
        su = s ? 3 : 1;
        st = s ? 1 : 2;
        ho = s ? 2 : 1;
        if (!w && ad == 2'd3) begin
            lat = 1; cs = 0; sf = -1; sc = 0; rd = 8'hFF; er = 1'b1;
        end else begin
            lat = su + st + ho; cs = su + st + ho; sf = su; sc = st;
            rd = w ? 8'h00 : din; er = 1'b0;
        end
    endfunction

    task automatic run_txn(input logic w, input logic [1:0] ad, input logic [7:0] wd, input logic [7:0] din,
                           output int lat, output int cs_cnt, output int sf, output int sc,
                           output logic [7:0] rd, output logic er, output int bad, output int rdy_hi);
        int   waitc;
        logic pcs, stb, ostb;
        logic [1:0] pa;
        logic [7:0] pd;
        lat = -1; cs_cnt = 0; sf = -1; sc = 0; rd = 8'h00; er = 1'b0; bad = 0; rdy_hi = 0;
        @(negedge clk);
        rw = w; ra = ad; rwd = wd; bus_din = din; rv = 1'b1;
        waitc = 0;
        while (!rdy[sel] && waitc < 20) begin
            @(negedge clk);
            waitc++;
        end
        if (!rdy[sel]) begin
            rv = 1'b0;
            bad++;
            return;
        end
        pcs = 1'b1; pa = 2'd0; pd = 8'h00;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (k == 0) rv = 1'b0;
            stb  = w ? wrn[sel] : rdn[sel];
            ostb = w ? rdn[sel] : wrn[sel];
            if (!ostb) bad++;
            if (!stb) begin
                if (sf < 0) sf = k;
                sc++;
            end
            if (doe[sel] != (w && !csn[sel])) bad++;
            if (!csn[sel]) begin
                cs_cnt++;
                if (aa[sel] != ad) bad++;
                if (w && dout[sel] != wd) bad++;
                if (!pcs && (aa[sel] != pa || dout[sel] != pd)) bad++;
            end
            pcs = csn[sel]; pa = aa[sel]; pd = dout[sel];
            if (rdy[sel]) rdy_hi++;
            if (rsvalid[sel]) begin
                lat = k; rd = rrd[sel]; er = rerr[sel];
                break;
            end
        end
        if (lat >= 0) begin
            @(posedge clk); #1;
            if (rsvalid[sel] || !rdy[sel]) bad++;
        end
    endtask

    task automatic check_txn(input string tag, input logic w, input logic [1:0] ad, input logic [7:0] wd,
                             input logic [7:0] din, input int elat, input logic [7:0] erd, input logic eer);
        int lat, cs, sf, sc, bad, rh, mlat, mcs, msf, msc;
        logic [7:0] rd, mrd;
        logic er, mer;
        model(sel, w, ad, din, mlat, mcs, msf, msc, mrd, mer);
        run_txn(w, ad, wd, din, lat, cs, sf, sc, rd, er, bad, rh);
        chk(tag, "latency", lat, elat);
        chk(tag, "rdata", int'(rd), int'(erd));
        chk(tag, "err", int'(er), int'(eer));
        chk(tag, "cs_low_cycles", cs, mcs);
        chk(tag, "strobe_first_edge", sf, msf);
        chk(tag, "strobe_cycles", sc, msc);
        chk(tag, "bus_violations", bad, 0);
        chk(tag, "ready_during_txn", rh, 0);
    endtask

    typedef struct {
        logic       w;
        logic [1:0] ad;
        logic [7:0] wd;
        logic [7:0] din;
        logic [7:0] erd;
        logic       eer;
        int         elat;
    } vec_t;

    vec_t vt [7];

    initial begin
        int waitc, r1, acc2, r2, rdy_early, nrsp, lat, cs, sf, sc;
        logic [7:0] rd2, mrd;
        logic mer;

        vt[0] = '{w: 1'b1, ad: 2'd3, wd: 8'h80, din: 8'h00, erd: 8'h00, eer: 1'b0, elat: 4};
        vt[1] = '{w: 1'b0, ad: 2'd1, wd: 8'h00, din: 8'h5A, erd: 8'h5A, eer: 1'b0, elat: 4};
        vt[2] = '{w: 1'b0, ad: 2'd3, wd: 8'h00, din: 8'h77, erd: 8'hFF, eer: 1'b1, elat: 1};
        vt[3] = '{w: 1'b1, ad: 2'd0, wd: 8'h11, din: 8'h00, erd: 8'h00, eer: 1'b0, elat: 4};
        vt[4] = '{w: 1'b0, ad: 2'd2, wd: 8'h00, din: 8'hC3, erd: 8'hC3, eer: 1'b0, elat: 4};
        vt[5] = '{w: 1'b0, ad: 2'd0, wd: 8'hFF, din: 8'h00, erd: 8'h00, eer: 1'b0, elat: 4};
        vt[6] = '{w: 1'b1, ad: 2'd2, wd: 8'hFF, din: 8'h99, erd: 8'h00, eer: 1'b0, elat: 4};

        rst_n = 1'b0; rv = 1'b0; rw = 1'b0; ra = 2'd0; rwd = 8'h00; bus_din = 8'h00; sel = 1'b0;

        // Reset values on both instances, then req_ready rises on the first edge after release.
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("reset", "outputs", int'({rdy[i], rsvalid[i], rrd[i], rerr[i], aa[i], csn[i], rdn[i], wrn[i], dout[i], doe[i]}),
                int'({1'b0, 1'b0, 8'h00, 1'b0, 2'b00, 1'b1, 1'b1, 1'b1, 8'h00, 1'b0}));
        end
        rst_n = 1'b1;
        #1;
        chk("reset", "ready_before_edge", int'(rdy[0]), 0);
        @(posedge clk); #1;
        chk("reset", "ready_after_edge", int'(rdy[0]), 1);

        for (int i = 0; i < 7; i++) begin
            sel = 1'b0;
            check_txn($sformatf("vec%0d", i), vt[i].w, vt[i].ad, vt[i].wd, vt[i].din, vt[i].elat, vt[i].erd, vt[i].eer);
        end

        // Swept timing: strobe after edge 3, released after edge 4, response after edge 6.
        sel = 1'b1;
        check_txn("sweep_write", 1'b1, 2'd1, 8'h42, 8'h00, 6, 8'h00, 1'b0);
        check_txn("sweep_read", 1'b0, 2'd2, 8'h00, 8'hA7, 6, 8'hA7, 1'b0);
        check_txn("sweep_illegal", 1'b0, 2'd3, 8'h00, 8'h12, 1, 8'hFF, 1'b1);

        // Back-to-back with req_valid held: write port A then read port C.
        sel = 1'b0;
        @(negedge clk);
        rw = 1'b1; ra = 2'd0; rwd = 8'h11; bus_din = 8'h3C; rv = 1'b1;
        waitc = 0;
        while (!rdy[0] && waitc < 20) begin
            @(negedge clk);
            waitc++;
        end
        r1 = -1; acc2 = -1; r2 = -1; rd2 = 8'h00; rdy_early = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (k == 0) begin
                rw = 1'b0; ra = 2'd2;
            end
            if (rdy[0] && (r1 < 0 || acc2 >= 0)) rdy_early++;
            if (acc2 >= 0 && rsvalid[0]) begin
                r2 = k; rd2 = rrd[0];
                break;
            end
            if (r1 < 0 && rsvalid[0]) r1 = k;
            if (r1 >= 0 && acc2 < 0 && !csn[0]) begin
                acc2 = k; rv = 1'b0;
            end
        end
        rv = 1'b0;
        chk("b2b", "first_rsp_edge", r1, 4);
        chk("b2b", "second_accept_edge", acc2, 6);
        chk("b2b", "second_rsp_edge", r2, 10);
        chk("b2b", "second_rdata", int'(rd2), 8'h3C);
        chk("b2b", "ready_during_txn", rdy_early, 0);
        repeat (2) @(posedge clk);

        // Randomised traffic on both instances against the model.
        for (int n = 0; n < 30; n++) begin
            logic w;
            logic [1:0] ad;
            logic [7:0] wd, din;
            sel = 1'($urandom_range(0, 1));
            w   = 1'($urandom_range(0, 1));
            ad  = 2'($urandom_range(0, 3));
            wd  = 8'($urandom_range(0, 255));
            din = 8'($urandom_range(0, 255));
            model(sel, w, ad, din, lat, cs, sf, sc, mrd, mer);
            check_txn($sformatf("rand%0d", n), w, ad, wd, din, lat, mrd, mer);
        end

        // Asynchronous reset while WRITE_N is low.
        sel = 1'b0;
        @(negedge clk);
        rw = 1'b1; ra = 2'd1; rwd = 8'hA5; rv = 1'b1;
        waitc = 0;
        while (!rdy[0] && waitc < 20) begin
            @(negedge clk);
            waitc++;
        end
        @(posedge clk); #1;
        rv = 1'b0;
        waitc = 0;
        while (wrn[0] && waitc < 10) begin
            @(posedge clk); #1;
            waitc++;
        end
        chk("midreset", "strobe_seen", int'(wrn[0]), 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midreset", "write_n", int'(wrn[0]), 1);
        chk("midreset", "cs_n", int'(csn[0]), 1);
        chk("midreset", "data_oe", int'(doe[0]), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        nrsp = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            if (rsvalid[0]) nrsp++;
        end
        chk("midreset", "rsp_after_abort", nrsp, 0);
        chk("midreset", "ready_after", int'(rdy[0]), 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/ppi_bus_master.md
# ppi_bus_master

Bus-cycle initiator that drives the PPI's CPU-side interface (address, chip select, read/write strobes, data bus) from a simple request/response handshake. A request is queued, then replayed as a properly timed 8255-style read or write cycle. It is the counterpart to the PPI register/port logic, which responds to these cycles. It sits between the system controller (or a scripted test sequencer) and the PPI top level.

## Interface
- SETUP_CYCLES, default 1: clocks that A/CS_N are valid before the strobe asserts; minimum 1.
- STROBE_CYCLES, default 2: clocks that READ_N/WRITE_N are held low; minimum 1.
- HOLD_CYCLES, default 1: clocks that A/CS_N/DATA are held after the strobe deasserts; minimum 1.
- CLK  in  1  single clock; all state changes on the rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when valid & ready at a rising edge.
- req_write  in  1  1 = write cycle, 0 = read cycle.
- req_addr  in  2  PPI address (0 port A, 1 port B, 2 port C, 3 control).
- req_wdata  in  8  write data.
- rsp_valid  out  1  one-cycle pulse when a transaction completes.
- rsp_rdata  out  8  read data, valid with rsp_valid; 0 for writes.
- rsp_err  out  1  with rsp_valid, set for a rejected request.
- A  out  2  PPI address.
- CS_N  out  1  chip select, active low.
- READ_N  out  1  read strobe, active low.
- WRITE_N  out  1  write strobe, active low.
- DATA_OUT  out  8  write data to the bus.
- DATA_OE  out  1  1 = DATA_OUT drives the bus.
- DATA_IN  in  8  bus data returned by the PPI.

## Operation
- States: IDLE, SETUP, STROBE, HOLD, RESP.
- IDLE: req_ready=1. On handshake with a legal request, latch addr/write/wdata and go to SETUP.
- SETUP: CS_N=0, A=latched addr, strobes high. Writes also drive DATA_OE=1 and DATA_OUT=wdata. Lasts SETUP_CYCLES, then goes to STROBE.
- STROBE: READ_N=0 (read) or WRITE_N=0 (write). Lasts STROBE_CYCLES, then goes to HOLD. For reads, DATA_IN is captured on the edge that leaves STROBE.
- HOLD: strobes high. A, CS_N and, for writes, DATA_OE/DATA_OUT are unchanged. Lasts HOLD_CYCLES, then goes to RESP.
- RESP: rsp_valid=1 for exactly one cycle. CS_N=1, DATA_OE=0. Goes to IDLE.
- Illegal request: a read with req_addr=3 (the control register is write-only).
  - Accepted, but no bus cycle is generated: CS_N and strobes stay high.
  - Goes directly to RESP with rsp_err=1 and rsp_rdata=8'hFF.
- Invariants:
  - READ_N and WRITE_N are never both low.
  - A strobe is never low while CS_N is high.
  - A and DATA_OUT never change while CS_N is low.
- All bus outputs are registered; no combinational path from req_* to the bus pins.

## Timing
- Reset values: req_ready=0 during reset and 1 from the first edge after release.
  - CS_N=1, READ_N=1, WRITE_N=1.
  - A=0, DATA_OUT=0, DATA_OE=0.
  - rsp_valid=0, rsp_rdata=0, rsp_err=0.
- Handshake at edge 0:
  - SETUP is visible after edge 0.
  - Strobe low after edge SETUP_CYCLES.
  - Strobe high after edge SETUP_CYCLES+STROBE_CYCLES.
  - rsp_valid high after edge N, where N = SETUP_CYCLES+STROBE_CYCLES+HOLD_CYCLES.
- Default latency is 4 cycles. An illegal request gives rsp_valid after edge 1.
- req_ready is low from SETUP through RESP. The next request is accepted no earlier than the edge after RESP.
- Asynchronous reset mid-transaction:
  - Strobes, CS_N and DATA_OE deassert immediately.
  - No rsp_valid is issued for the aborted request.
- Internal counters are wide enough for the largest parameter. They count parameter-1 down to 0 and do not wrap.

## Structure
- Package ppi_bus_pkg holds:
  - State enum.
  - Address constants PPI_PORT_A=0, PPI_PORT_B=1, PPI_PORT_C=2, PPI_CTRL=3.
  - Idle bus-level constants.
- One sub-module, ppi_bus_timer:
  - Loadable down-counter with a done flag.
  - Reloaded on each state entry.
  - Instantiated once and shared across SETUP, STROBE and HOLD.

## Test plan
- Reset: with RESET_N low, all outputs hold their reset values. Assert reset again while in STROBE: WRITE_N goes high immediately and no rsp_valid follows.
- Write: addr=3, wdata=8'h80, default params.
  - CS_N low for 4 cycles; WRITE_N low for exactly 2 of them.
  - DATA_OUT=8'h80 with DATA_OE=1 throughout CS_N low.
  - rsp_valid after 4 edges with rsp_err=0.
- Read: addr=1, with DATA_IN=8'h5A while READ_N is low. Response is rsp_rdata=8'h5A, rsp_err=0. DATA_OE stays 0 throughout.
- Illegal read: addr=3 read. No CS_N or strobe activity; rsp_valid after 1 edge with rsp_err=1 and rsp_rdata=8'hFF.
- Back-to-back: req_valid held high for a write to addr 0 (8'h11) followed by a read of addr 2.
  - req_ready is low during each transaction.
  - The second transaction is accepted on the edge after the first RESP.
  - WRITE_N and READ_N are never low together.
- Parameter sweep: SETUP=3, STROBE=1, HOLD=2. Strobe low after edge 3, high after edge 4, rsp_valid after edge 6.
